// File: rtl/multiway_traffic_controller.sv
// N-way round-robin signal controller; outputs registered, 1-cycle req-to-pend latency, no backpressure.
// Optional emergency preemption (preempt/preempt_way ports) is enabled by defining TLC_PREEMPT_EN.
module multiway_traffic_controller #(
  parameter int N_WAYS     = 4,
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  localparam int WAY_W     = $clog2(N_WAYS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_WAYS-1:0] req,
`ifdef TLC_PREEMPT_EN
  input  logic              preempt,
  input  logic [WAY_W-1:0]  preempt_way,
`endif
  output logic [N_WAYS-1:0] red,
  output logic [N_WAYS-1:0] yellow,
  output logic [N_WAYS-1:0] green,
  output logic [1:0]        state,
  output logic [WAY_W-1:0]  way
);

  localparam int MAX_CYC = (GREEN_MIN > YELLOW_CYC)
                         ? ((GREEN_MIN > ALLRED_CYC) ? GREEN_MIN : ALLRED_CYC)
                         : ((YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC);
  localparam int TW = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } phase_e;

  phase_e             state_q, state_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [N_WAYS-1:0]  pend_q, pend_d;
  logic [N_WAYS-1:0]  red_q, red_d;
  logic [N_WAYS-1:0]  yellow_q, yellow_d;
  logic [N_WAYS-1:0]  green_q, green_d;
  logic [WAY_W-1:0]   nxt_way;
  logic [WAY_W-1:0]   idx_w;
  logic               found;
  logic               pre_vld;

  always_comb begin
    state_d  = state_q;
    way_d    = way_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    nxt_way  = WAY_W'((int'(way_q) + 1) % N_WAYS);
    idx_w    = '0;
    found    = 1'b0;
    pre_vld  = 1'b0;
    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;

`ifdef TLC_PREEMPT_EN
    pre_vld = preempt && (int'(preempt_way) < N_WAYS);
`endif

    // Timer saturates at zero; zero means the current phase has expired.
    if (timer_q != '0) timer_d = timer_q - 1'b1;

    for (int i = 0; i < N_WAYS; i++) begin
      if (req[i] && !(state_q == ST_GREEN && way_q == WAY_W'(i))) pend_d[i] = 1'b1;
    end

    // Cyclic search starting just after the last-served way; smallest distance wins.
    for (int k = 1; k <= N_WAYS; k++) begin
      idx_w = WAY_W'((int'(way_q) + k) % N_WAYS);
      if (!found && pend_q[idx_w]) begin
        nxt_way = idx_w;
        found   = 1'b1;
      end
    end

`ifdef TLC_PREEMPT_EN
    if (pre_vld) nxt_way = preempt_way;
`endif

    case (state_q)
      ST_GREEN: begin
        if (pre_vld && nxt_way != way_q) begin
          state_d = ST_YELLOW;
          timer_d = TW'(YELLOW_CYC - 1);
        end else if (pre_vld) begin
          timer_d = '0;
        end else if (timer_q == '0 && |pend_q) begin
          state_d = ST_YELLOW;
          timer_d = TW'(YELLOW_CYC - 1);
        end
      end
      ST_YELLOW: begin
        if (timer_q == '0) begin
          state_d = ST_ALLRED;
          timer_d = TW'(ALLRED_CYC - 1);
        end
      end
      default: begin
        if (timer_q == '0) begin
          state_d         = ST_GREEN;
          way_d           = nxt_way;
          timer_d         = TW'(GREEN_MIN - 1);
          pend_d[nxt_way] = 1'b0;
        end
      end
    endcase

    for (int i = 0; i < N_WAYS; i++) begin
      if (way_d == WAY_W'(i)) begin
        red_d[i]    = (state_d == ST_ALLRED);
        yellow_d[i] = (state_d == ST_YELLOW);
        green_d[i]  = (state_d == ST_GREEN);
      end else begin
        red_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ALLRED;
      way_q    <= WAY_W'(N_WAYS - 1);
      timer_q  <= TW'(ALLRED_CYC - 1);
      pend_q   <= '0;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
    end else begin
      state_q  <= state_d;
      way_q    <= way_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
    end
  end

  assign red    = red_q;
  assign yellow = yellow_q;
  assign green  = green_q;
  assign state  = state_q;
  assign way    = way_q;

endmodule
